pc_unit: RTL and testbench

Parametrised program-counter unit for the RISC core, the successor to the plain 8-bit incrementing PC. Each enabled cycle it increments, jumps absolute, branches PC-relative, calls (pushing the return address onto a hardware return stack) or returns (popping that stack). It sits between the controller, which drives `op`/`en`, and the instruction ROM, which takes `pc_addr` as its read address. Stack overflow and underflow are reported through sticky flags.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_unit_ret_stack.sv | 68 ++++++
 rtl/pc_unit.sv | 109 ++++++++++
 tb/tb_pc_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: op width and op encodings
// driven by the controller.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC   = 3'd0;
    localparam logic [OP_W-1:0] OP_JMP   = 3'd1;
    localparam logic [OP_W-1:0] OP_BRREL = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL  = 3'd3;
    localparam logic [OP_W-1:0] OP_RET   = 3'd4;
    localparam logic [OP_W-1:0] OP_HOLD  = 3'd5;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO for the PC unit. Pushes when full and pops when empty
// are ignored; entries are never cleared, only the depth counter is reset.
module ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int DW = $clog2(STACK_DEPTH+1);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [DW-1:0]     depth_q;
    logic [DW-1:0]     depth_d;
    logic              pushOk;
    logic              popOk;

    assign full   = (depth_q == DW'(STACK_DEPTH));
    assign empty  = (depth_q == '0);
    assign depth  = depth_q;

    // A simultaneous push and pop resolves as a pop; the PC unit never issues both.
    assign popOk  = pop && !empty;
    assign pushOk = push && !full && !pop;

    always_comb begin
        depth_d = depth_q;
        if (pushOk) begin
            depth_d = depth_q + DW'(1);
        end else if (popOk) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                dout = mem_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (pushOk && depth_q == DW'(i)) begin
                mem_q[i] <= din;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, call/return through a hardware
// return stack, and sticky overflow/underflow flags.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic                               en,
    input  logic [OP_W-1:0]                    op,
    input  logic [ADDR_W-1:0]                  target,
    input  logic [ADDR_W-1:0]                  offset,
    input  logic                               err_clr,
    output logic [ADDR_W-1:0]                  pc_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf,
    output logic                               unf
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              ovf_q;
    logic              unf_q;
    logic              ovfSet;
    logic              unfSet;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pcPlusOne;
    logic [ADDR_W-1:0] retAddr;
    logic              stackFull;
    logic              stackEmpty;

    assign pcPlusOne = pc_q + ONE;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pcPlusOne),
        .dout  (retAddr),
        .depth (depth),
        .full  (stackFull),
        .empty (stackEmpty)
    );

    // A full-stack CALL still jumps; an empty-stack RET degrades to INC.
    always_comb begin
        pc_d   = pc_q;
        push   = 1'b0;
        pop    = 1'b0;
        ovfSet = 1'b0;
        unfSet = 1'b0;
        if (en) begin
            case (op)
                OP_INC:   pc_d = pcPlusOne;
                OP_JMP:   pc_d = target;
                OP_BRREL: pc_d = pc_q + offset;
                OP_CALL: begin
                    pc_d = target;
                    if (stackFull) begin
                        ovfSet = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stackEmpty) begin
                        pc_d   = pcPlusOne;
                        unfSet = 1'b1;
                    end else begin
                        pc_d = retAddr;
                        pop  = 1'b1;
                    end
                end
                default:  pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            pc_q  <= RESET_ADDR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovfSet || (ovf_q && !err_clr);
            unf_q <= unfSet || (unf_q && !err_clr);
        end
    end

    assign pc_addr     = pc_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign stack_full  = stackFull;
    assign stack_empty = stackEmpty;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised and directed bench for pc_unit with a queue-based reference
// model and a scoreboard monitor decoupled from the stimulus driver.
module tb_pc_unit;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int RESET_VAL   = 0;
    localparam int MODULUS     = 1 << ADDR_W;

    logic                 clock;
    logic                 rst;
    logic                 en;
    logic [2:0]           op;
    logic [ADDR_W-1:0]    target;
    logic [ADDR_W-1:0]    offset;
    logic                 err_clr;
    logic [ADDR_W-1:0]    pc_addr;
    logic [2:0]           depth;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 ovf;
    logic                 unf;

    pc_unit #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_ADDR  (8'(RESET_VAL))
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .en          (en),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .err_clr     (err_clr),
        .pc_addr     (pc_addr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf         (ovf),
        .unf         (unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int pc;
        int depth;
        int full;
        int empty;
        int ovf;
        int unf;
    } expect_t;

    expect_t sbQueue[$];
    expect_t monExp;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain integers and a queue used as a stack.
    int modelPc  = RESET_VAL;
    int modelStack[$];
    int modelOvf = 0;
    int modelUnf = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: one pending expectation per clock edge, sampled just after it.
    always @(posedge clock) begin
        #1;
        if (sbQueue.size() != 0) begin
            monExp = sbQueue.pop_front();
            checkOutput("pc_addr", int'(pc_addr), monExp.pc);
            checkOutput("depth", int'(depth), monExp.depth);
            checkOutput("stack_full", int'(stack_full), monExp.full);
            checkOutput("stack_empty", int'(stack_empty), monExp.empty);
            checkOutput("ovf", int'(ovf), monExp.ovf);
            checkOutput("unf", int'(unf), monExp.unf);
        end
    end

    task automatic applyStimulus(input bit r, input bit e, input int o,
                                 input int t, input int f, input bit c);
        expect_t exp;
        @(negedge clock);
        rst     = r;
        en      = e;
        op      = 3'(o);
        target  = 8'(t);
        offset  = 8'(f);
        err_clr = c;
        if (!r) begin
            modelPc = RESET_VAL;
            modelStack.delete();
            modelOvf = 0;
            modelUnf = 0;
        end else begin
            if (c) begin
                modelOvf = 0;
                modelUnf = 0;
            end
            if (e) begin
                case (o)
                    0: modelPc = (modelPc + 1) % MODULUS;
                    1: modelPc = t % MODULUS;
                    2: modelPc = (modelPc + f) % MODULUS;
                    3: begin
                        if (modelStack.size() == STACK_DEPTH) modelOvf = 1;
                        else modelStack.push_back((modelPc + 1) % MODULUS);
                        modelPc = t % MODULUS;
                    end
                    4: begin
                        if (modelStack.size() == 0) begin
                            modelUnf = 1;
                            modelPc  = (modelPc + 1) % MODULUS;
                        end else begin
                            modelPc = modelStack.pop_back();
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp.pc    = modelPc;
        exp.depth = modelStack.size();
        exp.full  = (modelStack.size() == STACK_DEPTH) ? 1 : 0;
        exp.empty = (modelStack.size() == 0) ? 1 : 0;
        exp.ovf   = modelOvf;
        exp.unf   = modelUnf;
        sbQueue.push_back(exp);
    endtask

    task automatic doOp(input int o, input int t, input int f);
        applyStimulus(1'b1, 1'b1, o, t, f, 1'b0);
    endtask

    initial begin
        int rOp;
        rst     = 1'b0;
        en      = 1'b0;
        op      = 3'd0;
        target  = '0;
        offset  = '0;
        err_clr = 1'b0;

        // Reset, increment, hold
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) doOp(0, 0, 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Wrap and relative branch
        doOp(1, 8'hFF, 0);
        doOp(0, 0, 0);
        doOp(1, 8'h10, 0);
        doOp(2, 0, 8'hFC);
        doOp(2, 0, 8'h05);

        // Nested call/return
        doOp(1, 8'h20, 0);
        doOp(3, 8'h40, 0);
        doOp(3, 8'h60, 0);
        doOp(4, 0, 0);
        doOp(4, 0, 0);

        // Call at all-ones pushes 0
        doOp(1, 8'hFF, 0);
        doOp(3, 8'h50, 0);
        doOp(4, 0, 0);

        // Overflow then unwind
        doOp(3, 8'h80, 0);
        doOp(3, 8'h90, 0);
        doOp(3, 8'hA0, 0);
        doOp(3, 8'hB0, 0);
        doOp(3, 8'hC0, 0);
        repeat (4) doOp(4, 0, 0);
        applyStimulus(1'b1, 1'b0, 5, 0, 0, 1'b1);

        // Underflow and clear
        doOp(1, 8'h30, 0);
        doOp(4, 0, 0);
        applyStimulus(1'b1, 1'b1, 5, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b1, 4, 0, 0, 1'b1);

        // Reset mid-sequence
        doOp(3, 8'h44, 0);
        doOp(3, 8'h55, 0);
        applyStimulus(1'b0, 1'b1, 3, 8'h66, 0, 1'b0);
        doOp(4, 0, 0);

        // Randomised phase, biased toward CALL/RET to exercise the stack edges
        for (int i = 0; i < 400; i++) begin
            rOp = int'($urandom_range(0, 9));
            if (rOp == 8) rOp = 3;
            if (rOp == 9) rOp = 4;
            applyStimulus(($urandom_range(0, 99) >= 3),
                          ($urandom_range(0, 99) < 85),
                          rOp,
                          int'($urandom_range(0, MODULUS - 1)),
                          int'($urandom_range(0, MODULUS - 1)),
                          ($urandom_range(0, 99) < 10));
        end

        for (int i = 0; i < 10 && sbQueue.size() != 0; i++) begin
            @(posedge clock);
        end
        #2;
        if (sbQueue.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sbQueue.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
